// File: rtl/iomem_uart_if.sv
// PicoRV32 iomem slave bus bundle: the CPU side drives the request,
// the peripheral answers with a one-cycle ready pulse and read data.
interface iomem_uart_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );
    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_uart.sv
// Memory-mapped UART for the PicoRV32 iomem bus: TX/RX FIFOs, programmable
// divisor, sticky error flags and a registered level interrupt.
module iomem_uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    // A pop on a full FIFO frees the slot for a same-cycle push; a pop on
    // an empty FIFO is ignored so the push still lands.
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign drop    = push & !do_push;
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

module iomem_uart #(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          DIV_RESET  = 868
) (
    input  logic            clk,
    input  logic            rst,
    iomem_uart_if.slave     bus,
    input  logic            uart_rxd,
    output logic            uart_txd,
    output logic            irq
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic                 sel, wr, rd, wr_st;
    logic [1:0]           off;
    logic [31:0]          rd_mux, status;
    logic [15:0]          div;
    logic                 en_rx, en_tx, tx_ovf, rx_ovr, frame_err;

    logic                 tx_push, tx_pop, tx_full, tx_empty, tx_drop;
    logic [DATA_BITS-1:0] tx_dout;
    logic [LW-1:0]        tx_level;
    logic                 rx_push, rx_pop, rx_full, rx_empty, rx_drop;
    logic [DATA_BITS-1:0] rx_dout;
    logic [LW-1:0]        rx_level;

    state_t               tx_state, rx_state;
    logic [15:0]          tx_cnt, rx_cnt;
    logic [3:0]           tx_bit, rx_bit;
    logic [DATA_BITS-1:0] tx_sh, rx_sh;
    logic                 rx_meta, rxs, rxs_d, rx_at_stop, ferr_set;

    assign sel   = bus.iomem_valid & (bus.iomem_addr[31:4] == BASE_ADDR[31:4]) & !bus.iomem_ready;
    assign wr    = sel & (|bus.iomem_wstrb);
    assign rd    = sel & ~(|bus.iomem_wstrb);
    assign off   = bus.iomem_addr[3:2];
    assign wr_st = wr & (off == 2'd1);

    assign tx_push = wr & (off == 2'd0);
    assign rx_pop  = rd & (off == 2'd0);

    iomem_uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .din(bus.iomem_wdata[DATA_BITS-1:0]),
        .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
        .drop(tx_drop), .level(tx_level)
    );

    iomem_uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_sh),
        .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
        .drop(rx_drop), .level(rx_level)
    );

    assign status = {16'd0, 8'(rx_level), (tx_state != S_IDLE), tx_ovf, frame_err, rx_ovr,
                     rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rd_mux = '0;
        case (off)
            2'd0:    rd_mux = rx_empty ? 32'd0 : 32'(rx_dout);
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {14'd0, en_tx, en_rx, div};
            default: rd_mux = '0;
        endcase
    end

    // Sticky flags: a same-cycle set beats a write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
            div             <= 16'(DIV_RESET);
            en_rx           <= 1'b0;
            en_tx           <= 1'b0;
            tx_ovf          <= 1'b0;
            rx_ovr          <= 1'b0;
            frame_err       <= 1'b0;
            irq             <= 1'b0;
        end else begin
            bus.iomem_ready <= sel;
            bus.iomem_rdata <= rd ? rd_mux : '0;
            if (wr && off == 2'd2) begin
                div   <= (bus.iomem_wdata[15:0] < 16'd4) ? 16'd4 : bus.iomem_wdata[15:0];
                en_rx <= bus.iomem_wdata[16];
                en_tx <= bus.iomem_wdata[17];
            end
            tx_ovf    <= tx_drop  | (tx_ovf    & !(wr_st & bus.iomem_wdata[6]));
            rx_ovr    <= rx_drop  | (rx_ovr    & !(wr_st & bus.iomem_wdata[4]));
            frame_err <= ferr_set | (frame_err & !(wr_st & bus.iomem_wdata[5]));
            irq       <= (en_rx & !rx_empty) | (en_tx & tx_empty) | rx_ovr | frame_err;
        end
    end

    // Pop at IDLE or at the end of STOP so back-to-back characters have no gap.
    assign tx_pop = !tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_cnt == 16'd0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            uart_txd <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            case (tx_state)
                S_IDLE: if (tx_pop) begin
                    tx_state <= S_START;
                    tx_sh    <= tx_dout;
                    uart_txd <= 1'b0;
                    tx_cnt   <= div - 16'd1;
                end
                S_START: if (tx_cnt == 16'd0) begin
                    tx_state <= S_DATA;
                    uart_txd <= tx_sh[0];
                    tx_sh    <= {1'b0, tx_sh[DATA_BITS-1:1]};
                    tx_bit   <= '0;
                    tx_cnt   <= div - 16'd1;
                end else tx_cnt <= tx_cnt - 16'd1;
                S_DATA: if (tx_cnt == 16'd0) begin
                    tx_cnt <= div - 16'd1;
                    if (tx_bit == 4'(DATA_BITS-1)) begin
                        tx_state <= S_STOP;
                        uart_txd <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 4'd1;
                        uart_txd <= tx_sh[0];
                        tx_sh    <= {1'b0, tx_sh[DATA_BITS-1:1]};
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                S_STOP: if (tx_cnt == 16'd0) begin
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx_sh    <= tx_dout;
                        uart_txd <= 1'b0;
                        tx_cnt   <= div - 16'd1;
                    end else tx_state <= S_IDLE;
                end else tx_cnt <= tx_cnt - 16'd1;
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign rx_at_stop = (rx_state == S_STOP) & (rx_cnt == 16'd0);
    assign rx_push    = rx_at_stop & rxs;
    assign ferr_set   = rx_at_stop & !rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            case (rx_state)
                S_IDLE: if (rxs_d && !rxs) begin
                    rx_state <= S_START;
                    rx_cnt   <= {1'b0, div[15:1]} - 16'd1;
                end
                S_START: if (rx_cnt == 16'd0) begin
                    rx_state <= rxs ? S_IDLE : S_DATA;
                    rx_bit   <= '0;
                    rx_cnt   <= div - 16'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                S_DATA: if (rx_cnt == 16'd0) begin
                    rx_sh  <= {rxs, rx_sh[DATA_BITS-1:1]};
                    rx_cnt <= div - 16'd1;
                    if (rx_bit == 4'(DATA_BITS-1)) rx_state <= S_STOP;
                    else                           rx_bit   <= rx_bit + 4'd1;
                end else rx_cnt <= rx_cnt - 16'd1;
                S_STOP: if (rx_cnt == 16'd0) rx_state <= S_IDLE;
                        else                 rx_cnt   <= rx_cnt - 16'd1;
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.iomem_addr[1:0], bus.iomem_wdata[31:18], tx_level};
endmodule

// File: doc/iomem_uart.md
# iomem_uart

Memory-mapped UART peripheral for the PicoRV32 iomem bus, generalised successor of the fixed on-chip UART. It attaches as one iomem slave of the microcontroller and drives the board TX/RX pins. Character width, FIFO depth, base address and reset baud divisor are parameters. TX/RX FIFOs, sticky error flags and a level interrupt are included.

## Interface
- `DATA_BITS`, 8: character width, 5..8.
- `FIFO_DEPTH`, 16: entries per TX and RX FIFO, power of two, at least 2.
- `BASE_ADDR`, 32'h0200_0000: slave base address; decode uses `iomem_addr[31:4]`.
- `DIV_RESET`, 868: reset value of the divisor register (clocks per bit).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle completion pulse.
- `iomem_wstrb` in 4: write strobes; 0 means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` is high.
- `uart_rxd` in 1: serial input, asynchronous to `clk`.
- `uart_txd` out 1: serial output, idles high.
- `irq` out 1: level interrupt.

## Operation
- Selection: `sel = iomem_valid & (iomem_addr[31:4] == BASE_ADDR[31:4]) & !iomem_ready`. Register offsets are selected by `addr[3:2]`.
- Offset 0x0, DATA:
  - Write pushes `wdata[DATA_BITS-1:0]` into the TX FIFO. If the TX FIFO is full, the data is dropped and `tx_ovf` is set.
  - Read pops the RX FIFO and returns the character zero-extended. An empty RX FIFO returns 0 and nothing is popped.
- Offset 0x4, STATUS. Read bits:
  - [0] `tx_full`, [1] `tx_empty`, [2] `rx_full`, [3] `rx_empty`.
  - [4] `rx_ovr`, [5] `frame_err`, [6] `tx_ovf` (these three are sticky).
  - [7] `tx_busy`.
  - [15:8] RX FIFO level.
  - Writing 1 to bits 4..6 clears the matching sticky flag.
- Offset 0x8, DIV: 16-bit clocks per bit. Writes below 4 are clamped to 4.
- Offset 0x8, IRQ_EN: bit [16] enables RX-not-empty; bit [17] enables TX-empty.
- Offset 0xC reads 0; writes to it are ignored.
- `irq` = (en_rx & !rx_empty) | (en_tx & tx_empty) | rx_ovr | frame_err. It is registered.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - Leaves IDLE when the TX FIFO is non-empty. The head character is popped on entry to START.
  - Each state holds the line for DIV clocks.
  - Bits are sent LSB first, DATA_BITS of them, followed by 1 stop bit.
  - Back-to-back characters need no idle gap.
- RX path starts with a 2-flop synchronizer. RX FSM, states IDLE → START → DATA → STOP:
  - A falling edge on the synchronized input in IDLE starts a frame. The line is sampled DIV/2 clocks later.
  - If the line is high at that sample, the start is false and the FSM returns to IDLE.
  - Data and stop bits are sampled every DIV clocks thereafter.
  - Stop bit low: set `frame_err` and discard the character.
  - RX FIFO full at stop: set `rx_ovr` and drop the new character.
- DIV changes take effect at the next bit boundary.
- Simultaneous push and pop on a FIFO:
  - Full FIFO: the pop wins and the push succeeds in the same cycle.
  - Empty FIFO: the push wins and the pop returns 0.
- Simultaneous set and clear of a sticky flag: the set wins.

## Timing
- Reset values:
  - `uart_txd` = 1; `iomem_ready` = 0; `iomem_rdata` = 0; `irq` = 0.
  - FIFOs empty; sticky flags 0; DIV = DIV_RESET; IRQ_EN = 0.
  - Both FSMs in IDLE.
- Bus: `iomem_ready` rises exactly one cycle after `sel`, and stays high for one cycle. Read data is registered with it.
- Reset mid-frame returns `uart_txd` high immediately (asynchronously) and discards any partial RX character.
- Frame length is (DATA_BITS+2)·DIV clocks.
- The start bit begins 2 clocks after the write that pushes into an idle, empty TX FIFO.

## Test plan
- **TX:** DIV=4, write 0xA5 → `uart_txd` shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 clocks wide; `tx_empty` returns to 1.
- **Loopback:** `uart_txd`→`uart_rxd`, DIV=8, write 0x00, 0xFF, 0x3C → three DATA reads return the same values in order; STATUS [15:8] reaches 3 before the reads.
- **Overflow:** FIFO_DEPTH=4, DIV=100, 6 rapid DATA writes → `tx_ovf`=1 and exactly 5 characters are transmitted (one popped, 4 queued). Writing 0x40 to STATUS clears `tx_ovf`.
- **RX errors:**
  - Frame 0x55 with stop bit low → `frame_err`=1, `rx_empty` stays 1, `irq`=1.
  - 1-DIV/4 low glitch → no character received.
- **RX overrun:** FIFO_DEPTH=2, 3 received characters with no reads → `rx_ovr`=1, and reads return the first two characters only.
- **Reset and decode:** assert `rst` mid-TX → `uart_txd`=1 in the same cycle. An access outside BASE_ADDR gets no `iomem_ready`.
